mode_controller: RTL and testbench
==================================

MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT_SEC, default 30, meaning the number of tick_1hz pulses without a button press before a set session aborts (range 1..63).
REQ-002 The block SHALL have port clk  input  1  the single system clock.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port tick_1hz  input  1  one-cycle pulse, once per second.
REQ-005 The block SHALL have ports pulsed_mode, pulsed_set, pulsed_up and pulsed_down, each  input  1  a debounced one-cycle button pulse.
REQ-006 The block SHALL have port set_busy  input  4  bit i is high while unit i's setter is in a non-idle state.
REQ-007 The block SHALL have port set_done  input  4  bit i is unit i's one-cycle propagate pulse.
REQ-008 The block SHALL have port mode  output  2  the selected unit: 0 CLK12, 1 CLK24, 2 ALARM, 3 STOPWATCH.
REQ-009 The block SHALL have port set_enable  output  4  one-hot enable for the selected unit's setter.
REQ-010 The block SHALL have ports route_set, route_up and route_down, each  output  4  the button pulse steered to unit i.
REQ-011 The block SHALL have port disp_sel  output  2  the display mux select.
REQ-012 The block SHALL have port setting  output  1  high while in state SETTING.
REQ-013 The block SHALL have port abort  output  1  a one-cycle pulse on timeout.

Function
REQ-014 The FSM SHALL have exactly two states: VIEW and SETTING.
REQ-015 In VIEW, pulsed_mode SHALL advance mode by one on the next cycle, wrapping 3->0.
REQ-016 In VIEW and SETTING, pulsed_set, pulsed_up and pulsed_down SHALL each be registered and driven only on bit [mode] of the matching route_* output, with 1-cycle latency; all other route bits SHALL stay 0.
REQ-017 If pulsed_mode and pulsed_set arrive in the same VIEW cycle, the set pulse SHALL be routed and the mode change SHALL be dropped.
REQ-018 VIEW->SETTING SHALL occur on the first cycle in which set_busy[mode] is high.
REQ-019 In SETTING, pulsed_mode SHALL be ignored and mode SHALL remain constant.
REQ-020 SETTING->VIEW SHALL occur on set_done[mode] or when set_busy[mode] falls, whichever comes first.
REQ-021 set_busy and set_done bits for unselected units SHALL be ignored.
REQ-022 set_enable SHALL equal the one-hot encoding of mode, except during an abort cycle (REQ-031).
REQ-023 disp_sel SHALL equal mode at all times.
REQ-024 setting SHALL be a registered output, high exactly while in SETTING.

Reset
REQ-025 While reset is low, the block SHALL asynchronously force: state VIEW, mode 0, set_enable 4'b0001, disp_sel 0, all route_* 0, setting 0, abort 0, timeout counter 0.
REQ-026 A reset asserted mid-SETTING SHALL return the block to VIEW with mode 0, and no route pulse or abort SHALL be emitted.
REQ-027 The first transition after release SHALL be on the first clk edge with reset high.

Configuration
REQ-028 With macro MODE_TIMEOUT_EN defined, a 6-bit counter SHALL count tick_1hz pulses while in SETTING and clear on any button pulse or on entry to SETTING.
REQ-029 Tick and button pulses arriving in the same cycle SHALL clear the counter (button wins).
REQ-030 The counter SHALL saturate and SHALL be held at 0 in VIEW.
REQ-031 With MODE_TIMEOUT_EN defined, when the count reaches TIMEOUT_SEC the block SHALL, on the next cycle: pulse abort for 1 cycle, drive set_enable to 0 for that cycle, and enter VIEW.
REQ-032 Without MODE_TIMEOUT_EN, abort SHALL be tied to 0, no counter SHALL exist, and SETTING SHALL exit only per REQ-020.

Structure
REQ-033 Shared package clock_ctrl_pkg SHALL hold the mode encoding constants (CLK12..STOPWATCH), the FSM state encoding, NUM_MODES = 4, and the one-hot helper function.
REQ-034 Sub-module inactivity_timer SHALL hold the counter, clear logic and compare against TIMEOUT_SEC, and SHALL be instantiated only under MODE_TIMEOUT_EN.

Verification
REQ-035 The bench SHALL cover: reset release, then 5 pulsed_mode pulses -> mode sequence 1,2,3,0,1; set_enable 0010,0100,1000,0001,0010.
REQ-036 The bench SHALL cover: mode=2, pulsed_up -> route_up=0100 exactly one cycle later; other route bits 0.
REQ-037 The bench SHALL cover: mode=1, set_busy[1]=1, then pulsed_mode -> setting=1, mode stays 1; set_done[1] pulse -> setting=0 next cycle.
REQ-038 The bench SHALL cover: pulsed_mode and pulsed_set in the same VIEW cycle at mode=0 -> route_set=0001, mode remains 0.
REQ-039 The bench SHALL cover, with MODE_TIMEOUT_EN and TIMEOUT_SEC=3: SETTING with 3 ticks and no buttons -> abort pulse, set_enable=0000 for 1 cycle, then VIEW; a button before the 3rd tick restarts the count.
REQ-040 The bench SHALL cover: reset asserted during SETTING with set_busy held -> outputs at reset values immediately; VIEW->SETTING recurs only after release.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock mode controller: mode encoding, FSM states
// and the mode-to-one-hot helper.
package clock_ctrl_pkg;

    localparam int unsigned NUM_MODES = 4;

    localparam logic [1:0] CLK12     = 2'd0;
    localparam logic [1:0] CLK24     = 2'd1;
    localparam logic [1:0] ALARM     = 2'd2;
    localparam logic [1:0] STOPWATCH = 2'd3;

    typedef enum logic {
        StView    = 1'b0,
        StSetting = 1'b1
    } state_e;

    function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [1:0] m);
        logic [NUM_MODES-1:0] oh;
        oh    = '0;
        oh[m] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts 1 Hz ticks while a set session is active; flags when the count hits
// TIMEOUT_SEC. Only instantiated when MODE_TIMEOUT_EN is defined.
module inactivity_timer #(
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic active_i,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam logic [5:0] Limit = 6'(TIMEOUT_SEC);

    logic [5:0] count_q, count_d;

    // A button in the same cycle as a tick wins and clears the count.
    always_comb begin
        count_d = count_q;
        if (!active_i || clear_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != 6'h3f)) begin
            count_d = count_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == Limit);

endmodule

// File: rtl/mode_controller.sv
// Selects which clock unit the buttons control and tracks its set session.
// Define MODE_TIMEOUT_EN to abort a set session after TIMEOUT_SEC idle seconds.
module mode_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       pulsed_mode,
    input  logic       pulsed_set,
    input  logic       pulsed_up,
    input  logic       pulsed_down,
    input  logic [3:0] set_busy,
    input  logic [3:0] set_done,
    output logic [1:0] mode,
    output logic [3:0] set_enable,
    output logic [3:0] route_set,
    output logic [3:0] route_up,
    output logic [3:0] route_down,
    output logic [1:0] disp_sel,
    output logic       setting,
    output logic       abort
);

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] set_enable_q, set_enable_d;
    logic [3:0] route_set_q, route_set_d;
    logic [3:0] route_up_q, route_up_d;
    logic [3:0] route_down_q, route_down_d;
    logic       setting_q, setting_d;
    logic       abort_q, abort_d;
    logic       timeout_hit;
    logic       any_button;

    assign any_button = pulsed_mode | pulsed_set | pulsed_up | pulsed_down;

`ifdef MODE_TIMEOUT_EN
    inactivity_timer #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_inactivity_timer (
        .clk       (clk),
        .reset     (reset),
        .active_i  (state_d == StSetting),
        .clear_i   (any_button || (state_q != StSetting)),
        .tick_i    (tick_1hz),
        .expired_o (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{tick_1hz, any_button, 6'(TIMEOUT_SEC)};
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        abort_d = 1'b0;
        unique case (state_q)
            StView: begin
                // A busy setter holds the mode; a same-cycle set press drops the mode step.
                if (set_busy[mode_q]) begin
                    state_d = StSetting;
                end else if (pulsed_mode && !pulsed_set) begin
                    mode_d = mode_q + 2'd1;
                end
            end
            StSetting: begin
                if (timeout_hit) begin
                    state_d = StView;
                    abort_d = 1'b1;
                end else if (set_done[mode_q] || !set_busy[mode_q]) begin
                    state_d = StView;
                end
            end
        endcase

        set_enable_d = abort_d ? 4'b0000 : mode_onehot(mode_d);
        route_set_d  = pulsed_set  ? mode_onehot(mode_q) : 4'b0000;
        route_up_d   = pulsed_up   ? mode_onehot(mode_q) : 4'b0000;
        route_down_d = pulsed_down ? mode_onehot(mode_q) : 4'b0000;
        setting_d    = (state_d == StSetting);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StView;
            mode_q       <= CLK12;
            set_enable_q <= 4'b0001;
            route_set_q  <= '0;
            route_up_q   <= '0;
            route_down_q <= '0;
            setting_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            set_enable_q <= set_enable_d;
            route_set_q  <= route_set_d;
            route_up_q   <= route_up_d;
            route_down_q <= route_down_d;
            setting_q    <= setting_d;
            abort_q      <= abort_d;
        end
    end

    assign mode       = mode_q;
    assign disp_sel   = mode_q;
    assign set_enable = set_enable_q;
    assign route_set  = route_set_q;
    assign route_up   = route_up_q;
    assign route_down = route_down_q;
    assign setting    = setting_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller; the timeout scenario is compiled in only
// when MODE_TIMEOUT_EN is defined, otherwise abort must stay low.
module tb_mode_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz, pulsed_mode, pulsed_set, pulsed_up, pulsed_down;
    logic [3:0] set_busy, set_done;
    logic [1:0] mode, disp_sel;
    logic [3:0] set_enable, route_set, route_up, route_down;
    logic       setting, abort;

    int total = 0;
    int bad   = 0;

    mode_controller #(
        .TIMEOUT_SEC (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .pulsed_mode (pulsed_mode),
        .pulsed_set  (pulsed_set),
        .pulsed_up   (pulsed_up),
        .pulsed_down (pulsed_down),
        .set_busy    (set_busy),
        .set_done    (set_done),
        .mode        (mode),
        .set_enable  (set_enable),
        .route_set   (route_set),
        .route_up    (route_up),
        .route_down  (route_down),
        .disp_sel    (disp_sel),
        .setting     (setting),
        .abort       (abort)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        pulsed_mode = 1'b1;
        step();
        pulsed_mode = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {tick_1hz, pulsed_mode, pulsed_set, pulsed_up, pulsed_down} = '0;
        set_busy = '0;
        set_done = '0;
        step();
        step();
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
        total++; if (set_enable !== 4'b0001) begin bad++; $display("FAIL reset_en got=%b want=0001", set_enable); end
        total++; if ({route_set, route_up, route_down} !== 12'h000) begin bad++; $display("FAIL reset_route got=%h want=000", {route_set, route_up, route_down}); end
        total++; if ({setting, abort, disp_sel} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {setting, abort, disp_sel}); end
        reset = 1'b1;
        step();
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL release_mode got=%0d want=0", mode); end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [3:0] exp_en   [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            pulse_mode();
            total++; if (mode !== exp_mode[i]) begin bad++; $display("FAIL cycle_mode[%0d] got=%0d want=%0d", i, mode, exp_mode[i]); end
            total++; if (set_enable !== exp_en[i]) begin bad++; $display("FAIL cycle_en[%0d] got=%b want=%b", i, set_enable, exp_en[i]); end
            total++; if (disp_sel !== exp_mode[i]) begin bad++; $display("FAIL cycle_disp[%0d] got=%0d want=%0d", i, disp_sel, exp_mode[i]); end
        end
    endtask

    task automatic test_route();
        pulse_mode();  // mode 1 -> 2
        pulsed_up = 1'b1;
        step();
        pulsed_up = 1'b0;
        total++; if (route_up !== 4'b0100) begin bad++; $display("FAIL route_up got=%b want=0100", route_up); end
        total++; if ({route_set, route_down} !== 8'h00) begin bad++; $display("FAIL route_others got=%h want=00", {route_set, route_down}); end
        pulsed_down = 1'b1;
        step();
        pulsed_down = 1'b0;
        total++; if (route_up !== 4'b0000) begin bad++; $display("FAIL route_up_clear got=%b want=0000", route_up); end
        total++; if (route_down !== 4'b0100) begin bad++; $display("FAIL route_down got=%b want=0100", route_down); end
        step();
        total++; if (route_down !== 4'b0000) begin bad++; $display("FAIL route_down_clear got=%b want=0000", route_down); end
    endtask

    task automatic test_setting();
        pulse_mode();
        pulse_mode();
        pulse_mode();  // 2 -> 3 -> 0 -> 1
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL set_premode got=%0d want=1", mode); end
        set_busy = 4'b0010;
        step();
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL set_enter got=%b want=1", setting); end
        pulse_mode();
        total++; if (mode !== 2'd1) begin bad++; $display("FAIL set_mode_hold got=%0d want=1", mode); end
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL set_stay got=%b want=1", setting); end
        pulsed_set = 1'b1;
        set_done   = 4'b0001;  // unselected unit, ignored
        step();
        pulsed_set = 1'b0;
        set_done   = 4'b0000;
        total++; if (route_set !== 4'b0010) begin bad++; $display("FAIL set_route got=%b want=0010", route_set); end
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL set_unsel_done got=%b want=1", setting); end
        set_done = 4'b0010;
        set_busy = 4'b0000;
        step();
        set_done = 4'b0000;
        total++; if (setting !== 1'b0) begin bad++; $display("FAIL set_done_exit got=%b want=0", setting); end
        set_busy = 4'b0010;
        step();
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL set_reenter got=%b want=1", setting); end
        set_busy = 4'b0000;
        step();
        total++; if (setting !== 1'b0) begin bad++; $display("FAIL set_busy_fall got=%b want=0", setting); end
    endtask

    task automatic test_same_cycle();
        pulse_mode();
        pulse_mode();
        pulse_mode();  // 1 -> 2 -> 3 -> 0
        pulsed_mode = 1'b1;
        pulsed_set  = 1'b1;
        step();
        pulsed_mode = 1'b0;
        pulsed_set  = 1'b0;
        total++; if (route_set !== 4'b0001) begin bad++; $display("FAIL same_route got=%b want=0001", route_set); end
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL same_mode got=%0d want=0", mode); end
        step();
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL same_mode_later got=%0d want=0", mode); end
    endtask

    task automatic test_timeout();
        set_busy = 4'b0001;
        step();
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL to_enter got=%b want=1", setting); end
`ifdef MODE_TIMEOUT_EN
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
        pulsed_up = 1'b1;  // restarts the count
        step();
        pulsed_up = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
        total++; if ({abort, setting} !== 2'b01) begin bad++; $display("FAIL to_restart got=%b want=01", {abort, setting}); end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        total++; if (abort !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", abort); end
        step();
        set_busy = 4'b0000;
        total++; if (abort !== 1'b1) begin bad++; $display("FAIL to_abort got=%b want=1", abort); end
        total++; if (set_enable !== 4'b0000) begin bad++; $display("FAIL to_en_off got=%b want=0000", set_enable); end
        total++; if (setting !== 1'b0) begin bad++; $display("FAIL to_view got=%b want=0", setting); end
        step();
        total++; if (abort !== 1'b0) begin bad++; $display("FAIL to_abort_once got=%b want=0", abort); end
        total++; if (set_enable !== 4'b0001) begin bad++; $display("FAIL to_en_back got=%b want=0001", set_enable); end
`else
        for (int i = 0; i < 6; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            total++; if ({abort, setting} !== 2'b01) begin bad++; $display("FAIL noto_tick[%0d] got=%b want=01", i, {abort, setting}); end
        end
        set_busy = 4'b0000;
        step();
        total++; if (setting !== 1'b0) begin bad++; $display("FAIL noto_exit got=%b want=0", setting); end
`endif
    endtask

    task automatic test_reset_mid_setting();
        pulse_mode();  // 0 -> 1
        set_busy = 4'b0010;
        step();
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL rst_pre got=%b want=1", setting); end
        reset      = 1'b0;
        set_busy   = 4'b0011;
        pulsed_set = 1'b1;
        #1;
        total++; if ({mode, setting, abort} !== 4'b0000) begin bad++; $display("FAIL rst_async got=%b want=0000", {mode, setting, abort}); end
        total++; if (set_enable !== 4'b0001) begin bad++; $display("FAIL rst_async_en got=%b want=0001", set_enable); end
        step();
        step();
        pulsed_set = 1'b0;
        total++; if ({setting, route_set} !== 5'b00000) begin bad++; $display("FAIL rst_hold got=%b want=00000", {setting, route_set}); end
        reset = 1'b1;
        step();
        total++; if (setting !== 1'b1) begin bad++; $display("FAIL rst_reenter got=%b want=1", setting); end
        total++; if (mode !== 2'd0) begin bad++; $display("FAIL rst_mode got=%0d want=0", mode); end
        set_busy = 4'b0000;
        step();
        total++; if (setting !== 1'b0) begin bad++; $display("FAIL rst_exit got=%b want=0", setting); end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_route();
        test_setting();
        test_same_cycle();
        test_timeout();
        test_reset_mid_setting();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
